// File: rtl/trs80_pkg.sv
// Shared constants and types for the TRS-80 Model I keyboard emulator.
// Scancode prefixes, matrix index widths and the PS/2 receiver state encoding.
package trs80_pkg;

  localparam logic [7:0] PS2_BREAK  = 8'hF0;
  localparam logic [7:0] PS2_EXT    = 8'hE0;
  localparam logic [7:0] PS2_LSHIFT = 8'h12;
  localparam logic [7:0] PS2_RSHIFT = 8'h59;

  localparam int ROW_W = 3;
  localparam int COL_W = 3;

  typedef enum logic [1:0] {
    RX_IDLE,
    RX_DATA,
    RX_PARITY,
    RX_STOP
  } rx_state_e;

endpackage

// File: rtl/trs80_keyboard_if.sv
// CPU-side read bus of the keyboard window: row-select address, chip select, read data.
interface trs80_keyboard_if;

  logic [7:0] cpu_addr;
  logic       keyboard_cs_n;
  logic [7:0] keyboard_dout;

  modport master (output cpu_addr, output keyboard_cs_n, input keyboard_dout);
  modport slave  (input cpu_addr, input keyboard_cs_n, output keyboard_dout);

endinterface

// File: rtl/trs80_key_map.sv
// Combinational PS/2 set-2 scancode to Model I matrix position lookup.
// Table entries are written as 6-bit octal: first digit row, second digit column.
module trs80_key_map
  import trs80_pkg::*;
(
  input  logic             ext_i,
  input  logic [7:0]       code_i,
  output logic             valid_o,
  output logic [ROW_W-1:0] row_o,
  output logic [COL_W-1:0] col_o
);

  logic [5:0] rc;

  always_comb begin
    valid_o = 1'b1;
    rc      = 6'o00;
    case ({ext_i, code_i})
      9'h00E: rc = 6'o00;  9'h01C: rc = 6'o01;  9'h032: rc = 6'o02;  9'h021: rc = 6'o03;
      9'h023: rc = 6'o04;  9'h024: rc = 6'o05;  9'h02B: rc = 6'o06;  9'h034: rc = 6'o07;
      9'h033: rc = 6'o10;  9'h043: rc = 6'o11;  9'h03B: rc = 6'o12;  9'h042: rc = 6'o13;
      9'h04B: rc = 6'o14;  9'h03A: rc = 6'o15;  9'h031: rc = 6'o16;  9'h044: rc = 6'o17;
      9'h04D: rc = 6'o20;  9'h015: rc = 6'o21;  9'h02D: rc = 6'o22;  9'h01B: rc = 6'o23;
      9'h02C: rc = 6'o24;  9'h03C: rc = 6'o25;  9'h02A: rc = 6'o26;  9'h01D: rc = 6'o27;
      9'h022: rc = 6'o30;  9'h035: rc = 6'o31;  9'h01A: rc = 6'o32;
      9'h045: rc = 6'o40;  9'h016: rc = 6'o41;  9'h01E: rc = 6'o42;  9'h026: rc = 6'o43;
      9'h025: rc = 6'o44;  9'h02E: rc = 6'o45;  9'h036: rc = 6'o46;  9'h03D: rc = 6'o47;
      9'h03E: rc = 6'o50;  9'h046: rc = 6'o51;  9'h052: rc = 6'o52;  9'h04C: rc = 6'o53;
      9'h041: rc = 6'o54;  9'h04E: rc = 6'o55;  9'h049: rc = 6'o56;  9'h04A: rc = 6'o57;
      9'h05A: rc = 6'o60;  9'h16C: rc = 6'o61;  9'h076: rc = 6'o62;  9'h175: rc = 6'o63;
      9'h172: rc = 6'o64;  9'h16B: rc = 6'o65;  9'h174: rc = 6'o66;  9'h029: rc = 6'o67;
      {1'b0, PS2_LSHIFT}: rc = 6'o70;
      default: valid_o = 1'b0;
    endcase
  end

  assign row_o = rc[5:3];
  assign col_o = rc[2:0];

endmodule

// File: rtl/trs80_keyboard.sv
// TRS-80 Model I keyboard: PS/2 receiver, scancode decoder, 8x8 matrix and row-OR read port.
// Define TRS80_KBD_PARITY_CHECK_EN to drop frames whose odd parity is wrong.
module trs80_keyboard
  import trs80_pkg::*;
#(
  parameter int FILTER_LEN     = 8,
  parameter int TIMEOUT_CYCLES = 50000
) (
  input  logic clock,
  input  logic reset_n,
  input  logic ps2_clk,
  input  logic ps2_data,
  trs80_keyboard_if.slave bus
);

  localparam int FW = $clog2(FILTER_LEN + 1);
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

  logic [1:0]    clkSync_q, dataSync_q;
  logic [FW-1:0] filtCnt_q;
  logic          filtClk_q, strobe_q;

  // Synchronise both lines; the clock additionally needs FILTER_LEN agreeing samples to toggle.
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      clkSync_q  <= 2'b11;
      dataSync_q <= 2'b11;
      filtCnt_q  <= '0;
      filtClk_q  <= 1'b1;
      strobe_q   <= 1'b0;
    end else begin
      clkSync_q  <= {clkSync_q[0], ps2_clk};
      dataSync_q <= {dataSync_q[0], ps2_data};
      strobe_q   <= 1'b0;
      if (clkSync_q[1] == filtClk_q) begin
        filtCnt_q <= '0;
      end else if (filtCnt_q == FW'(FILTER_LEN - 1)) begin
        filtClk_q <= clkSync_q[1];
        filtCnt_q <= '0;
        strobe_q  <= filtClk_q;
      end else begin
        filtCnt_q <= filtCnt_q + FW'(1);
      end
    end
  end

  rx_state_e     state_q;
  logic [7:0]    shift_q, byte_q;
  logic [2:0]    bitCnt_q;
  logic [TW-1:0] timer_q;
  logic          byteValid_q;
  logic          parityOk;

`ifdef TRS80_KBD_PARITY_CHECK_EN
  logic parity_q;
  assign parityOk = ^{shift_q, parity_q};
`else
  assign parityOk = 1'b1;
`endif

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      state_q     <= RX_IDLE;
      shift_q     <= '0;
      byte_q      <= '0;
      bitCnt_q    <= '0;
      timer_q     <= '0;
      byteValid_q <= 1'b0;
`ifdef TRS80_KBD_PARITY_CHECK_EN
      parity_q    <= 1'b0;
`endif
    end else begin
      byteValid_q <= 1'b0;
      if (state_q == RX_IDLE || strobe_q) timer_q <= '0;
      else                                timer_q <= timer_q + TW'(1);
      if (state_q != RX_IDLE && timer_q == TW'(TIMEOUT_CYCLES - 1)) begin
        state_q <= RX_IDLE;
      end else if (strobe_q) begin
        case (state_q)
          RX_IDLE: begin
            if (!dataSync_q[1]) begin
              state_q  <= RX_DATA;
              bitCnt_q <= '0;
            end
          end
          RX_DATA: begin
            shift_q  <= {dataSync_q[1], shift_q[7:1]};
            bitCnt_q <= bitCnt_q + 3'd1;
            if (bitCnt_q == 3'd7) state_q <= RX_PARITY;
          end
          RX_PARITY: begin
`ifdef TRS80_KBD_PARITY_CHECK_EN
            parity_q <= dataSync_q[1];
`endif
            state_q <= RX_STOP;
          end
          RX_STOP: begin
            if (dataSync_q[1] && parityOk) begin
              byteValid_q <= 1'b1;
              byte_q      <= shift_q;
            end
            state_q <= RX_IDLE;
          end
          default: state_q <= RX_IDLE;
        endcase
      end
    end
  end

  logic             brk_q, ext_q, rshift_q;
  logic [7:0][7:0]  matrix_q;
  logic             mapValid;
  logic [ROW_W-1:0] mapRow;
  logic [COL_W-1:0] mapCol;

  trs80_key_map uKeyMap (
    .ext_i   (ext_q),
    .code_i  (byte_q),
    .valid_o (mapValid),
    .row_o   (mapRow),
    .col_o   (mapCol)
  );

  // Right shift lives outside the matrix so either shift key alone keeps row 7 bit 0 set.
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      brk_q    <= 1'b0;
      ext_q    <= 1'b0;
      rshift_q <= 1'b0;
      matrix_q <= '0;
    end else if (byteValid_q) begin
      if (byte_q == PS2_BREAK) begin
        brk_q <= 1'b1;
      end else if (byte_q == PS2_EXT) begin
        ext_q <= 1'b1;
      end else begin
        if (!ext_q && byte_q == PS2_RSHIFT) rshift_q <= !brk_q;
        else if (mapValid)                  matrix_q[mapRow][mapCol] <= !brk_q;
        brk_q <= 1'b0;
        ext_q <= 1'b0;
      end
    end
  end

  logic [7:0][7:0] rowRead;
  logic [7:0]      dout;

  always_comb begin
    rowRead       = matrix_q;
    rowRead[7][0] = matrix_q[7][0] | rshift_q;
    dout          = '0;
    if (!bus.keyboard_cs_n) begin
      for (int r = 0; r < 8; r++) begin
        if (bus.cpu_addr[r]) dout = dout | rowRead[r];
      end
    end
  end

  assign bus.keyboard_dout = dout;

endmodule

// File: tb/tb_trs80_keyboard.sv
// Scoreboard bench for trs80_keyboard: PS/2 frames in, matrix reads checked by a monitor.
// Honours TRS80_KBD_PARITY_CHECK_EN for the bad-parity expectation.
module tb_trs80_keyboard;

  localparam int HALF = 30;
  localparam int GAP  = 120;
  localparam int TMO  = 1000;

  logic clock = 1'b0;
  logic reset_n = 1'b0;
  logic ps2Clk = 1'b1;
  logic ps2Data = 1'b1;
  logic readReq = 1'b0;

  int checkCount = 0;
  int errorCount = 0;
  logic [7:0] expQ[$];
  string      nameQ[$];

  trs80_keyboard_if kbdBus ();

  trs80_keyboard #(.FILTER_LEN(8), .TIMEOUT_CYCLES(TMO)) dut (
    .clock    (clock),
    .reset_n  (reset_n),
    .ps2_clk  (ps2Clk),
    .ps2_data (ps2Data),
    .bus      (kbdBus)
  );

  always #5 clock = ~clock;

  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  task automatic checkOutput(input logic [7:0] actual);
    logic [7:0] exp;
    string      nm;
    exp = expQ.pop_front();
    nm  = nameQ.pop_front();
    checkCount++;
    if (actual !== exp) begin
      errorCount++;
      $display("[TB] FAIL %s: got %02h expected %02h", nm, actual, exp);
    end
  endtask

  // Monitor: sample the read data mid-cycle whenever a read is presented.
  always @(negedge clock) begin
    if (readReq) checkOutput(kbdBus.keyboard_dout);
  end

  task automatic applyStimulus(input logic [7:0] addr, input logic csN,
                               input logic [7:0] exp, input string nm);
    @(posedge clock);
    kbdBus.cpu_addr      = addr;
    kbdBus.keyboard_cs_n = csN;
    expQ.push_back(exp);
    nameQ.push_back(nm);
    readReq = 1'b1;
    @(posedge clock);
    readReq = 1'b0;
  endtask

  task automatic sendBits(input logic [10:0] bits, input int n);
    for (int i = 0; i < n; i++) begin
      ps2Data = bits[i];
      repeat (HALF) @(posedge clock);
      ps2Clk = 1'b0;
      repeat (HALF) @(posedge clock);
      ps2Clk = 1'b1;
    end
    ps2Data = 1'b1;
  endtask

  task automatic sendByte(input logic [7:0] b, input logic badPar);
    logic par;
    par = (~^b) ^ badPar;
    sendBits({1'b1, par, b, 1'b0}, 11);
    repeat (GAP) @(posedge clock);
  endtask

  task automatic press(input logic [7:0] b);
    sendByte(b, 1'b0);
  endtask

  task automatic release_key(input logic [7:0] b);
    sendByte(8'hF0, 1'b0);
    sendByte(b, 1'b0);
  endtask

  initial begin
    kbdBus.cpu_addr      = 8'hFF;
    kbdBus.keyboard_cs_n = 1'b0;
    repeat (5) @(posedge clock);
    applyStimulus(8'hFF, 1'b0, 8'h00, "reset_all_rows");
    reset_n = 1'b1;
    repeat (20) @(posedge clock);
    applyStimulus(8'hFF, 1'b0, 8'h00, "post_reset_idle");

    press(8'h1C);
    applyStimulus(8'h01, 1'b0, 8'h02, "make_A_row0");
    applyStimulus(8'h02, 1'b0, 8'h00, "make_A_row1_clear");
    release_key(8'h1C);
    applyStimulus(8'h01, 1'b0, 8'h00, "break_A");

    press(8'h1C);
    press(8'h5A);
    applyStimulus(8'h41, 1'b0, 8'h03, "A_enter_rows06");
    applyStimulus(8'hFF, 1'b0, 8'h03, "A_enter_all_rows");
    applyStimulus(8'h40, 1'b0, 8'h01, "enter_row6");
    applyStimulus(8'hFF, 1'b1, 8'h00, "cs_high");
    applyStimulus(8'h00, 1'b0, 8'h00, "addr_zero");
    release_key(8'h1C);
    release_key(8'h5A);
    applyStimulus(8'hFF, 1'b0, 8'h00, "A_enter_released");

    press(8'h12);
    press(8'h59);
    applyStimulus(8'h80, 1'b0, 8'h01, "both_shifts");
    release_key(8'h12);
    applyStimulus(8'h80, 1'b0, 8'h01, "rshift_only");
    release_key(8'h59);
    applyStimulus(8'h80, 1'b0, 8'h00, "no_shift");
    press(8'h59);
    applyStimulus(8'h80, 1'b0, 8'h01, "rshift_alone");
    release_key(8'h59);

    press(8'hE0);
    press(8'h75);
    applyStimulus(8'h40, 1'b0, 8'h08, "ext_up");
    sendByte(8'hE0, 1'b0);
    release_key(8'h75);
    applyStimulus(8'h40, 1'b0, 8'h00, "ext_up_release");
    press(8'h75);
    applyStimulus(8'hFF, 1'b0, 8'h00, "plain_75_unmapped");
    press(8'h05);
    applyStimulus(8'hFF, 1'b0, 8'h00, "unmapped_05");

    press(8'h1C);
    press(8'h1C);
    applyStimulus(8'h01, 1'b0, 8'h02, "repeat_make");
    press(8'h32);
    press(8'h1A);
    applyStimulus(8'h01, 1'b0, 8'h06, "A_B_row0");
    applyStimulus(8'h08, 1'b0, 8'h04, "Z_row3");
    applyStimulus(8'h09, 1'b0, 8'h06, "rows03_or");
    release_key(8'h1C);
    release_key(8'h32);
    release_key(8'h1A);
    applyStimulus(8'hFF, 1'b0, 8'h00, "multi_released");

    press(8'h45);
    press(8'h4A);
    applyStimulus(8'h30, 1'b0, 8'h81, "digit0_slash");
    release_key(8'h45);
    release_key(8'h4A);

    sendBits({1'b1, 1'b0, 8'h1C, 1'b0}, 5);
    repeat (TMO + 500) @(posedge clock);
    press(8'h1C);
    applyStimulus(8'h01, 1'b0, 8'h02, "after_timeout");
    release_key(8'h1C);
    applyStimulus(8'h01, 1'b0, 8'h00, "after_timeout_rel");

    sendBits({1'b1, 1'b0, 8'h1C, 1'b0}, 4);
    reset_n = 1'b0;
    repeat (4) @(posedge clock);
    reset_n = 1'b1;
    repeat (20) @(posedge clock);
    press(8'h1C);
    applyStimulus(8'h01, 1'b0, 8'h02, "after_mid_reset");
    release_key(8'h1C);

    sendByte(8'h1C, 1'b1);
`ifdef TRS80_KBD_PARITY_CHECK_EN
    applyStimulus(8'h01, 1'b0, 8'h00, "bad_parity_dropped");
`else
    applyStimulus(8'h01, 1'b0, 8'h02, "bad_parity_accepted");
`endif
    release_key(8'h1C);
    applyStimulus(8'h01, 1'b0, 8'h00, "final_clear");

    repeat (5) @(posedge clock);
    checkCount++;
    if (expQ.size() != 0) begin
      errorCount++;
      $display("[TB] FAIL scoreboard_drain: %0d left, expected 0", expQ.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checkCount, errorCount);
    $finish;
  end

endmodule
